load_store_unit: RTL

- Multi-cycle load/store unit between the core datapath and a valid/ready data-memory bus.
- Datapath side: takes ALU_result as the address and register rs2 as store data. Returns sign/zero-extended load data for the result mux.
- Generates byte strobes, word-aligns addresses and detects misalignment.
- Holds the core through `stall` until the access completes. Replaces the ideal single-cycle data memory.

---
 rtl/load_store_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: bridges the core datapath (ALU_result as address, rs2 as
// store data) to a valid/ready data-memory bus, one access at a time.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-low reset
//   req_valid/req_we  access request from the core (1 = store)
//   funct3            RISC-V width/sign field
//   addr, wdata       byte address and raw store data
//   stall             holds the core until the access reaches DONE
//   rdata, fault      extended load data and status (00 ok, 01 misaligned or
//                     illegal, 10 bus timeout), meaningful in DONE
//   mem_*             word-aligned bus request / response channel
module load_store_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic [1:0]  fault,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t      state_q, state_d;
    logic        mem_req_valid_q, mem_req_valid_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  fault_q, fault_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;

    logic        dec_ok;
    logic [3:0]  strb;
    logic [31:0] lanes;

    // Shift the addressed byte/half down to bit 0, then sign/zero-extend.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  extend_load = {{24{sh[7]}}, sh[7:0]};
            3'b100:  extend_load = {24'b0, sh[7:0]};
            3'b001:  extend_load = {{16{sh[15]}}, sh[15:0]};
            3'b101:  extend_load = {16'b0, sh[15:0]};
            default: extend_load = sh;
        endcase
    endfunction

    // Width/alignment decode; unsigned widths only exist for loads.
    always_comb begin
        dec_ok = 1'b0;
        strb   = 4'b0000;
        lanes  = wdata;
        case (funct3)
            3'b000: begin
                dec_ok = 1'b1;
                strb   = 4'b0001 << addr[1:0];
                lanes  = {4{wdata[7:0]}};
            end
            3'b001: begin
                dec_ok = ~addr[0];
                strb   = 4'b0011 << addr[1:0];
                lanes  = {2{wdata[15:0]}};
            end
            3'b010: begin
                dec_ok = (addr[1:0] == 2'b00);
                strb   = 4'b1111;
            end
            3'b100:  dec_ok = ~req_we;
            3'b101:  dec_ok = ~req_we & ~addr[0];
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wstrb_d     = mem_wstrb_q;
        mem_wdata_d     = mem_wdata_q;
        rdata_d         = rdata_q;
        fault_d         = fault_q;
        cnt_d           = cnt_q;
        off_d           = off_q;
        f3_d            = f3_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rdata_d = 32'b0;
                    if (dec_ok) begin
                        off_d           = addr[1:0];
                        f3_d            = funct3;
                        mem_we_d        = req_we;
                        mem_addr_d      = {addr[31:2], 2'b00};
                        mem_wstrb_d     = req_we ? strb : 4'b0000;
                        mem_wdata_d     = req_we ? lanes : 32'b0;
                        mem_req_valid_d = 1'b1;
                        fault_d         = 2'b00;
                        state_d         = REQ;
                    end else begin
                        // Rejected without touching the bus.
                        fault_d = 2'b01;
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    cnt_d           = '0;
                    state_d         = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    rdata_d = mem_we_q ? 32'b0 : extend_load(mem_rdata, off_q, f3_q);
                    fault_d = 2'b00;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(TIMEOUT)) begin
                        fault_d = 2'b10;
                        rdata_d = 32'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= 32'b0;
            mem_wstrb_q     <= 4'b0;
            mem_wdata_q     <= 32'b0;
            rdata_q         <= 32'b0;
            fault_q         <= 2'b00;
            cnt_q           <= '0;
            off_q           <= 2'b00;
            f3_q            <= 3'b000;
        end else begin
            state_q         <= state_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wstrb_q     <= mem_wstrb_d;
            mem_wdata_q     <= mem_wdata_d;
            rdata_q         <= rdata_d;
            fault_q         <= fault_d;
            cnt_q           <= cnt_d;
            off_q           <= off_d;
            f3_q            <= f3_d;
        end
    end

    // Combinational so the core is held in the very cycle the request appears.
    assign stall         = req_valid & (state_q != DONE);
    assign rdata         = rdata_q;
    assign fault         = fault_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign mem_wdata     = mem_wdata_q;
endmodule
